debug_loader: RTL and testbench
===============================

// Module: debug_loader
// PURPOSE
// Program loader directly upstream of the core's debug port. Consumes a byte stream from the
// debug UART receiver. Assembles little-endian 32-bit instructions. Drives DEBUG_SIG/DEBUG_addr/
// DEBUG_instr/clk_debug into the frontend instruction memory. Holds the core in load mode until
// the image and its checksum have been received.
// PARAMETERS
// BASE_ADDR   32'h0000_0000  byte address of the first instruction written
// MAX_WORDS   16'd4096       largest accepted word count N
// TIMEOUT     24'd1_000_000  idle clk cycles allowed between bytes mid-load before error
// START_BYTE  8'hA5          command byte that opens a load
// PORTS
// clk          in   1   core clock; the only clock
// rst          in   1   reset: one clock; reset is synchronous and active-high
// rx_valid     in   1   rx_data valid this cycle; single-cycle strobe, one byte per strobe
// rx_data      in   8   received byte
// DEBUG_SIG    out  1   high while a load is in progress (LEN0..CSUM)
// DEBUG_addr   out  32  instruction-memory byte address of DEBUG_instr
// DEBUG_instr  out  32  assembled instruction word
// clk_debug    out  1   one-cycle write strobe to instruction memory (registered, glitch-free)
// load_done    out  1   sticky: last load completed with a good checksum
// load_err     out  1   sticky: last load aborted (length, checksum or timeout)
// words_cnt    out  16  words written in the current or last load
// BEHAVIOUR
// Reset: state=IDLE. All outputs 0. DEBUG_addr=BASE_ADDR. Byte/word counters, checksum and
//   timeout counter cleared. Reset mid-load aborts with no further clk_debug pulses.
// Frame: START_BYTE, N[7:0], N[15:8], N*4 data bytes (LSB first per word), CSUM.
//   CSUM = XOR of all 4N data bytes; length bytes are excluded.
// FSM, transitions only on rx_valid except timeout:
//   IDLE: START_BYTE -> LEN0; clear load_done, load_err, words_cnt, checksum; DEBUG_addr=BASE_ADDR.
//     Other bytes are ignored.
//   LEN0: latch N low -> LEN1.
//   LEN1: latch N high. N>MAX_WORDS -> ERR. N==0 -> CSUM. Else -> DATA.
//   DATA: shift byte into asm[31:0] at lane byte_idx (0..3). XOR into checksum.
//     byte_idx==3 -> WRITE.
//   WRITE (1 cycle, no rx consumed): DEBUG_instr<=assembled word.
//     DEBUG_addr<=BASE_ADDR+4*words_cnt. words_cnt++.
//     Next state CSUM if words_cnt+1==N, else DATA.
//   CSUM: byte==checksum -> DONE (load_done=1). Else -> ERR (load_err=1).
//   DONE/ERR (1 cycle): DEBUG_SIG falls -> IDLE. Flags stay set until the next START_BYTE.
// clk_debug: high exactly the cycle after WRITE. DEBUG_addr/DEBUG_instr are stable from WRITE+1
//   until the next WRITE, so they are valid before, during and after the strobe.
// rx_valid in WRITE cycle: byte is not dropped. A 1-entry skid register captures it and it is
//   consumed in the following DATA/CSUM cycle. Back-to-back bytes every clk are therefore
//   sustained. A second byte arriving while the skid is full sets load_err (overrun) -> ERR.
// Timeout: counter is cleared on each rx_valid and runs in LEN0..CSUM.
//   Reaching TIMEOUT -> ERR. Inactive in IDLE.
// START_BYTE mid-frame is treated as data (no resync).
// Address arithmetic is modulo 2^32. words_cnt cannot exceed MAX_WORDS.
// DEBUG_SIG=1 in LEN0, LEN1, DATA, WRITE, CSUM; 0 in IDLE, DONE, ERR.
// TESTING
// T1 load N=2: A5 02 00 13 05 10 00 93 05 20 00 CS=XOR -> two clk_debug pulses.
//    Writes 0x00100513@BASE and 0x00200593@BASE+4. load_done=1, DEBUG_SIG low after CSUM+1.
// T2 bad checksum: same frame, CSUM^8'h01 -> load_err=1, load_done=0.
//    Words still written, words_cnt=2.
// T3 N=0: A5 00 00 00 -> no clk_debug, load_done=1. N=MAX_WORDS+1 -> ERR after LEN1.
// T4 bytes on every consecutive clk (incl. WRITE cycle) for N=3 -> 3 correct writes, no overrun.
//    Two bytes while the skid register is full -> load_err.
// T5 stall TIMEOUT cycles after byte 5 of data -> load_err, DEBUG_SIG=0.
//    Reissue of a full frame succeeds.
// T6 rst asserted mid-DATA -> all outputs 0 next cycle. Stray non-A5 bytes in IDLE are ignored.

Source files
------------

// File: rtl/debug_loader.sv
// Debug-port program loader: turns a UART byte stream into little-endian instruction
// words for the frontend instruction memory and holds the core in load mode meanwhile.
module debug_loader #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [15:0] MAX_WORDS  = 16'd4096,
  parameter logic [23:0] TIMEOUT    = 24'd1_000_000,
  parameter logic [7:0]  START_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        DEBUG_SIG,
  output logic [31:0] DEBUG_addr,
  output logic [31:0] DEBUG_instr,
  output logic        clk_debug,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] words_cnt
);

  // state | meaning
  // IDLE  | waiting for START_BYTE, other bytes ignored
  // LEN0  | expecting N[7:0]
  // LEN1  | expecting N[15:8], range check
  // DATA  | assembling the current word, one or two bytes per cycle
  // WRITE | present word to instruction memory, byte arriving now goes to skid
  // CSUM  | expecting checksum byte (possibly already in skid)
  // DONE  | good load, single cycle
  // ERR   | aborted load, single cycle
  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_e;

  state_e state_q, state_d;

  logic [15:0] n_q, n_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] asm_q, asm_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  skid_q, skid_d;
  logic        skid_vld_q, skid_vld_d;
  logic [23:0] tmr_q, tmr_d;
  logic [15:0] words_q, words_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic        clk_dbg_q, clk_dbg_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        active, start, timed_out, merge, byte_avail, word_full;
  logic [7:0]  byte0;
  logic [15:0] n_full, words_inc;
  logic [2:0]  last_lane;
  logic [1:0]  idx_p1;

  // The skid can only be full on the first DATA cycle after WRITE (lane 0), so draining it
  // together with a fresh byte into lanes 0 and 1 keeps one-byte-per-clock streams lossless.
  always_comb begin
    active     = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA) ||
                 (state_q == S_WRITE) || (state_q == S_CSUM);
    start      = (state_q == S_IDLE) && rx_valid && (rx_data == START_BYTE);
    timed_out  = active && !rx_valid && (tmr_q == '0);
    merge      = skid_vld_q && rx_valid;
    byte_avail = skid_vld_q || rx_valid;
    byte0      = skid_vld_q ? skid_q : rx_data;
    n_full     = {rx_data, n_q[7:0]};
    words_inc  = words_q + 16'd1;
    idx_p1     = idx_q + 2'd1;
    last_lane  = {1'b0, idx_q} + {2'b00, merge};
    word_full  = byte_avail && (last_lane == 3'd3);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timed_out) begin
      state_d = S_ERR;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_LEN0;
        S_LEN0:  if (rx_valid) state_d = S_LEN1;
        S_LEN1: begin
          if (rx_valid) begin
            if (n_full > MAX_WORDS) state_d = S_ERR;
            else if (n_full == '0)  state_d = S_CSUM;
            else                    state_d = S_DATA;
          end
        end
        S_DATA:  if (word_full) state_d = S_WRITE;
        S_WRITE: begin
          if (rx_valid && skid_vld_q) state_d = S_ERR;
          else if (words_inc == n_q)  state_d = S_CSUM;
          else                        state_d = S_DATA;
        end
        S_CSUM: begin
          if (merge)           state_d = S_ERR;
          else if (byte_avail) state_d = (byte0 == csum_q) ? S_DONE : S_ERR;
        end
        S_DONE:  state_d = S_IDLE;
        S_ERR:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    DEBUG_SIG  = active;
    n_d        = n_q;
    idx_d      = idx_q;
    asm_d      = asm_q;
    csum_d     = csum_q;
    skid_d     = skid_q;
    skid_vld_d = 1'b0;
    tmr_d      = (!active || rx_valid) ? (TIMEOUT - 24'd1) :
                 ((tmr_q == '0) ? tmr_q : (tmr_q - 24'd1));
    words_d    = words_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    clk_dbg_d  = (state_q == S_WRITE);
    done_d     = done_q;
    err_d      = err_q;

    if (start) begin
      done_d  = 1'b0;
      err_d   = 1'b0;
      words_d = '0;
      csum_d  = '0;
      idx_d   = '0;
      addr_d  = BASE_ADDR;
    end

    case (state_q)
      S_LEN0: if (rx_valid) n_d[7:0]  = rx_data;
      S_LEN1: if (rx_valid) n_d[15:8] = rx_data;
      S_DATA: begin
        if (byte_avail && !timed_out) begin
          asm_d[{idx_q, 3'b000} +: 8] = byte0;
          csum_d = csum_q ^ byte0;
          if (merge) begin
            asm_d[{idx_p1, 3'b000} +: 8] = rx_data;
            csum_d = csum_d ^ rx_data;
          end
          idx_d = word_full ? 2'd0 : (last_lane[1:0] + 2'd1);
        end
      end
      S_WRITE: begin
        instr_d = asm_q;
        addr_d  = BASE_ADDR + {14'd0, words_q, 2'b00};
        words_d = words_inc;
        if (rx_valid) begin
          skid_d     = rx_data;
          skid_vld_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (state_d == S_DONE) done_d = 1'b1;
    if ((state_d == S_ERR) && (state_q != S_ERR)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q        <= '0;
      idx_q      <= '0;
      asm_q      <= '0;
      csum_q     <= '0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      tmr_q      <= '0;
      words_q    <= '0;
      addr_q     <= BASE_ADDR;
      instr_q    <= '0;
      clk_dbg_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      n_q        <= n_d;
      idx_q      <= idx_d;
      asm_q      <= asm_d;
      csum_q     <= csum_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      tmr_q      <= tmr_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      clk_dbg_q  <= clk_dbg_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign DEBUG_addr  = addr_q;
  assign DEBUG_instr = instr_q;
  assign clk_debug   = clk_dbg_q;
  assign load_done   = done_q;
  assign load_err    = err_q;
  assign words_cnt   = words_q;

endmodule

// File: tb/tb_debug_loader.sv
// Bench for debug_loader: table of frames, hand-written corner sequences and random frames
// checked against a frame-level model of the loader.
module tb_debug_loader;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [15:0] MAXW = 16'd8;
  localparam logic [23:0] TMO  = 24'd64;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data  = 8'h00;
  logic        DEBUG_SIG, clk_debug, load_done, load_err;
  logic [31:0] DEBUG_addr, DEBUG_instr;
  logic [15:0] words_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  frame_data[$];

  typedef struct {
    int n;
    bit flip;
    int gap;
    bit done;
    bit err;
    int words;
  } vec_t;
  vec_t vecs[9];

  debug_loader #(
    .BASE_ADDR(BASE), .MAX_WORDS(MAXW), .TIMEOUT(TMO), .START_BYTE(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .DEBUG_SIG(DEBUG_SIG), .DEBUG_addr(DEBUG_addr), .DEBUG_instr(DEBUG_instr),
    .clk_debug(clk_debug), .load_done(load_done), .load_err(load_err),
    .words_cnt(words_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (clk_debug) begin
      wr_addr.push_back(DEBUG_addr);
      wr_data.push_back(DEBUG_instr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    rx_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_byte(logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_g(logic [7:0] b, int gap_max);
    send_byte(b);
    if (gap_max > 0) idle($urandom_range(0, gap_max));
  endtask

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] data_xor();
    logic [7:0] x = 8'h00;
    foreach (frame_data[i]) x ^= frame_data[i];
    return x;
  endfunction

  task automatic fill_data(int n);
    frame_data.delete();
    if (n <= int'(MAXW))
      for (int i = 0; i < 4 * n; i++) frame_data.push_back(8'($urandom));
  endtask

  task automatic clear_writes();
    wr_addr.delete();
    wr_data.delete();
  endtask

  // Expected writes: word i is bytes 4i..4i+3 little-endian at BASE + 4i.
  task automatic check_writes(string nm, int n);
    int exp_n;
    exp_n = (n <= int'(MAXW)) ? n : 0;
    check({nm, ":nwr"}, 32'(wr_addr.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < wr_addr.size(); i++) begin
      check($sformatf("%s:addr%0d", nm, i), wr_addr[i], BASE + 32'(4 * i));
      check($sformatf("%s:data%0d", nm, i), wr_data[i],
            {frame_data[4*i+3], frame_data[4*i+2], frame_data[4*i+1], frame_data[4*i]});
    end
  endtask

  task automatic run_frame(string nm, int n, logic [7:0] cs, int gap_max,
                           bit ed, bit ee, int ew);
    logic [15:0] nn;
    nn = 16'(n);
    clear_writes();
    send_g(8'hA5, gap_max);
    send_g(nn[7:0], gap_max);
    send_g(nn[15:8], gap_max);
    if (n <= int'(MAXW)) begin
      foreach (frame_data[i]) send_g(frame_data[i], gap_max);
      send_g(cs, gap_max);
    end
    idle(4);
    check({nm, ":done"},  32'(load_done), 32'(ed));
    check({nm, ":err"},   32'(load_err),  32'(ee));
    check({nm, ":words"}, 32'(words_cnt), 32'(ew));
    check({nm, ":sig"},   32'(DEBUG_SIG), 32'd0);
    check_writes(nm, n);
  endtask

  task automatic t1_frame(string nm, bit flip);
    logic [7:0] b [11];
    b = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    clear_writes();
    foreach (b[i]) send_byte(b[i]);
    idle(1);
    check({nm, ":sig_csum"}, 32'(DEBUG_SIG), 32'd1);
    send_byte(8'hB0 ^ {7'd0, flip});
    check({nm, ":sig_after"}, 32'(DEBUG_SIG), 32'd0);
    check({nm, ":done"}, 32'(load_done), 32'(!flip));
    check({nm, ":err"},  32'(load_err),  32'(flip));
    idle(2);
    check({nm, ":words"}, 32'(words_cnt), 32'd2);
    check({nm, ":nwr"}, 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check({nm, ":a0"}, wr_addr[0], BASE);
      check({nm, ":d0"}, wr_data[0], 32'h0010_0513);
      check({nm, ":a1"}, wr_addr[1], BASE + 32'd4);
      check({nm, ":d1"}, wr_data[1], 32'h0020_0593);
    end
  endtask

  task automatic check_reset_outputs(string nm);
    check({nm, ":sig"},   32'(DEBUG_SIG), 32'd0);
    check({nm, ":addr"},  DEBUG_addr, BASE);
    check({nm, ":instr"}, DEBUG_instr, 32'd0);
    check({nm, ":strobe"}, 32'(clk_debug), 32'd0);
    check({nm, ":done"},  32'(load_done), 32'd0);
    check({nm, ":err"},   32'(load_err), 32'd0);
    check({nm, ":words"}, 32'(words_cnt), 32'd0);
  endtask

  initial begin
    logic [7:0] cs, xr;
    int n, gap;
    bit ed, ee;
    int ew;

    vecs[0] = '{0,   1'b0, 0, 1'b1, 1'b0, 0};
    vecs[1] = '{0,   1'b1, 0, 1'b0, 1'b1, 0};
    vecs[2] = '{9,   1'b0, 0, 1'b0, 1'b1, 0};
    vecs[3] = '{256, 1'b0, 1, 1'b0, 1'b1, 0};
    vecs[4] = '{8,   1'b0, 1, 1'b1, 1'b0, 8};
    vecs[5] = '{1,   1'b0, 2, 1'b1, 1'b0, 1};
    vecs[6] = '{3,   1'b0, 0, 1'b1, 1'b0, 3};
    vecs[7] = '{3,   1'b1, 0, 1'b0, 1'b1, 3};
    vecs[8] = '{5,   1'b0, 3, 1'b1, 1'b0, 5};

    rst = 1'b1;
    repeat (2) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    t1_frame("t1", 1'b0);
    t1_frame("t2", 1'b1);

    for (int i = 0; i < 9; i++) begin
      fill_data(vecs[i].n);
      cs = data_xor() ^ {7'd0, vecs[i].flip};
      run_frame($sformatf("vec%0d", i), vecs[i].n, cs, vecs[i].gap,
                vecs[i].done, vecs[i].err, vecs[i].words);
    end

    // Checksum lands in the skid during the last WRITE, then one more byte: overrun.
    fill_data(1);
    clear_writes();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    foreach (frame_data[i]) send_byte(frame_data[i]);
    send_byte(data_xor());
    send_byte(8'h00);
    idle(4);
    check("ovr:err",   32'(load_err),  32'd1);
    check("ovr:done",  32'(load_done), 32'd0);
    check("ovr:words", 32'(words_cnt), 32'd1);
    check_writes("ovr", 1);

    // Stall after the fifth data byte.
    fill_data(2);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    for (int i = 0; i < 5; i++) send_byte(frame_data[i]);
    idle(int'(TMO) - 1);
    check("tmo:sig_before", 32'(DEBUG_SIG), 32'd1);
    check("tmo:err_before", 32'(load_err),  32'd0);
    idle(1);
    check("tmo:err", 32'(load_err),  32'd1);
    check("tmo:sig", 32'(DEBUG_SIG), 32'd0);
    idle(2);
    fill_data(2);
    run_frame("tmo_reissue", 2, data_xor(), 1, 1'b1, 1'b0, 2);

    // Reset in the middle of DATA, then stray bytes in IDLE.
    fill_data(2);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    for (int i = 0; i < 6; i++) send_byte(frame_data[i]);
    clear_writes();
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    send_byte(8'h11); send_byte(8'h5A); send_byte(8'hFF);
    idle(6);
    check("stray:sig",   32'(DEBUG_SIG), 32'd0);
    check("stray:nwr",   32'(wr_addr.size()), 32'd0);
    check("stray:words", 32'(words_cnt), 32'd0);
    check("stray:done",  32'(load_done), 32'd0);

    for (int k = 0; k < 25; k++) begin
      n = $urandom_range(0, int'(MAXW) + 1);
      fill_data(n);
      xr = data_xor();
      cs = ($urandom_range(0, 1) == 1) ? xr : 8'($urandom);
      gap = $urandom_range(0, 3);
      if (n > int'(MAXW)) begin
        ed = 1'b0; ee = 1'b1; ew = 0;
      end else begin
        ed = (cs == xr); ee = !ed; ew = n;
      end
      run_frame($sformatf("rnd%0d", k), n, cs, gap, ed, ee, ew);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
